// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - 8-bit ALU execution datapath (add/sub, Booth multiply, non-restoring divide); optional flags via ALU_DP_STATUS_FLAGS_EN

module alu_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             adder_en,
    input  logic             subtractor_en,
    input  logic             booth_load,
    input  logic             booth_add_en,
    input  logic             booth_sub_en,
    input  logic             booth_shift_en,
    input  logic             booth_count_en,
    input  logic             divider_load,
    input  logic             divider_add_en,
    input  logic             divider_sub_en,
    input  logic             divider_shift_en,
    input  logic             divider_count_en,
    input  logic             divider_final_add,
    output logic [1:0]       booth_bits,
    output logic             booth_counter_done,
    output logic             divider_sign_R,
    output logic             divider_counter_done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_ovf,
    output logic             flag_dbz
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    // Iteration counters start at WIDTH-1 so that done is seen during the last count strobe
    localparam logic [2:0] CNT_INIT = 3'(WIDTH - 1);

    logic [1:0]       op_sel;
    logic [WIDTH-1:0] s;
    logic             c;

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] mq;
    logic             mq_1;
    logic [2:0]       mcount;

    logic [WIDTH+1:0] r;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] d;
    logic [2:0]       dcount;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH+1:0] r_add;
    logic [WIDTH+1:0] r_sub;

    assign sum_full = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff     = operand_a - operand_b;
    assign r_add    = r + {2'b00, d};
    assign r_sub    = r - {2'b00, d};

    // Operation class: add/sub strobes win over multiplier/divider loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_sel <= OP_ADD;
        end else if (adder_en) begin
            op_sel <= OP_ADD;
        end else if (subtractor_en) begin
            op_sel <= OP_SUB;
        end else if (booth_load) begin
            op_sel <= OP_MUL;
        end else if (divider_load) begin
            op_sel <= OP_DIV;
        end
    end

    // Single-cycle add / subtract with carry or unsigned borrow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s <= '0;
            c <= 1'b0;
        end else if (adder_en) begin
            {c, s} <= sum_full;
        end else if (subtractor_en) begin
            s <= diff;
            c <= (operand_a < operand_b);
        end
    end

    // Booth multiplier registers; one strobe acts per edge, highest priority first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            m      <= '0;
            mq     <= '0;
            mq_1   <= 1'b0;
            mcount <= '0;
        end else if (booth_load) begin
            acc    <= '0;
            mq     <= operand_a;
            mq_1   <= 1'b0;
            m      <= {operand_b[WIDTH-1], operand_b};
            mcount <= CNT_INIT;
        end else if (booth_add_en) begin
            acc <= acc + m;
        end else if (booth_sub_en) begin
            acc <= acc - m;
        end else if (booth_shift_en) begin
            {acc, mq, mq_1} <= {acc[WIDTH], acc, mq};
        end else if (booth_count_en) begin
            if (mcount != 3'd0) begin
                mcount <= mcount - 3'd1;
            end
        end
    end

    // Non-restoring divider registers; quotient bit is the inverted sign of the new remainder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r      <= '0;
            dq     <= '0;
            d      <= '0;
            dcount <= '0;
        end else if (divider_load) begin
            r      <= '0;
            dq     <= operand_a;
            d      <= operand_b;
            dcount <= CNT_INIT;
        end else if (divider_add_en) begin
            r     <= r_add;
            dq[0] <= ~r_add[WIDTH+1];
        end else if (divider_sub_en) begin
            r     <= r_sub;
            dq[0] <= ~r_sub[WIDTH+1];
        end else if (divider_shift_en) begin
            {r, dq} <= {r[WIDTH:0], dq, 1'b0};
        end else if (divider_count_en) begin
            if (dcount != 3'd0) begin
                dcount <= dcount - 3'd1;
            end
        end else if (divider_final_add) begin
            if (r[WIDTH+1]) begin
                r <= r_add;
            end
        end
    end

    assign booth_bits           = {mq[0], mq_1};
    assign booth_counter_done   = (mcount == 3'd0);
    assign divider_sign_R       = r[WIDTH+1];
    assign divider_counter_done = (dcount == 3'd0);

    // Result mux selected by the recorded operation class
    always_comb begin
        result_lo = s;
        result_hi = {{(WIDTH-1){1'b0}}, c};
        case (op_sel)
            OP_MUL: begin
                result_lo = mq;
                result_hi = acc[WIDTH-1:0];
            end
            OP_DIV: begin
                result_lo = dq;
                result_hi = r[WIDTH-1:0];
            end
            default: begin
                result_lo = s;
                result_hi = {{(WIDTH-1){1'b0}}, c};
            end
        endcase
    end

`ifdef ALU_DP_STATUS_FLAGS_EN
    logic ovf_r;
    logic dbz_r;
    logic res_valid;
    logic add_ovf;
    logic sub_ovf;

    assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum_full[WIDTH-1] != operand_a[WIDTH-1]);
    assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);

    // Flag state: overflow captured with the operands, divide-by-zero latched at divider load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r     <= 1'b0;
            dbz_r     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (adder_en || subtractor_en || booth_load || divider_load) begin
                res_valid <= 1'b1;
            end
            if (adder_en) begin
                ovf_r <= add_ovf;
            end else if (subtractor_en) begin
                ovf_r <= sub_ovf;
            end
            if (divider_load) begin
                dbz_r <= (operand_b == '0);
            end else if (adder_en || subtractor_en || booth_load) begin
                dbz_r <= 1'b0;
            end
        end
    end

    // Zero/negative track the selected result width; flags stay low until a first operation
    always_comb begin
        flag_zero = 1'b0;
        flag_neg  = 1'b0;
        if (op_sel == OP_MUL) begin
            flag_zero = res_valid && ({result_hi, result_lo} == '0);
            flag_neg  = res_valid && result_hi[WIDTH-1];
        end else begin
            flag_zero = res_valid && (result_lo == '0);
            flag_neg  = res_valid && result_lo[WIDTH-1];
        end
    end

    assign flag_ovf = res_valid && !op_sel[1] && ovf_r;
    assign flag_dbz = dbz_r;
`else
    assign flag_zero = 1'b0;
    assign flag_neg  = 1'b0;
    assign flag_ovf  = 1'b0;
    assign flag_dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - self-checking bench for alu_datapath against an arithmetic reference model

module tb_alu_datapath;

    typedef enum int {S_ADD, S_SUB, S_BLOAD, S_BADD, S_BSUB, S_BSHIFT, S_BCOUNT,
                      S_DLOAD, S_DADD, S_DSUB, S_DSHIFT, S_DCOUNT, S_DFINAL} strobe_e;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] operand_a, operand_b;
    logic       adder_en, subtractor_en;
    logic       booth_load, booth_add_en, booth_sub_en, booth_shift_en, booth_count_en;
    logic       divider_load, divider_add_en, divider_sub_en, divider_shift_en, divider_count_en, divider_final_add;
    logic [1:0] booth_bits;
    logic       booth_counter_done, divider_sign_R, divider_counter_done;
    logic [7:0] result_lo, result_hi;
    logic       flag_zero, flag_neg, flag_ovf, flag_dbz;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_datapath #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
        .adder_en(adder_en), .subtractor_en(subtractor_en),
        .booth_load(booth_load), .booth_add_en(booth_add_en), .booth_sub_en(booth_sub_en),
        .booth_shift_en(booth_shift_en), .booth_count_en(booth_count_en),
        .divider_load(divider_load), .divider_add_en(divider_add_en), .divider_sub_en(divider_sub_en),
        .divider_shift_en(divider_shift_en), .divider_count_en(divider_count_en),
        .divider_final_add(divider_final_add),
        .booth_bits(booth_bits), .booth_counter_done(booth_counter_done),
        .divider_sign_R(divider_sign_R), .divider_counter_done(divider_counter_done),
        .result_lo(result_lo), .result_hi(result_hi),
        .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_ovf(flag_ovf), .flag_dbz(flag_dbz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_strobes();
        adder_en = 0; subtractor_en = 0;
        booth_load = 0; booth_add_en = 0; booth_sub_en = 0; booth_shift_en = 0; booth_count_en = 0;
        divider_load = 0; divider_add_en = 0; divider_sub_en = 0; divider_shift_en = 0;
        divider_count_en = 0; divider_final_add = 0;
    endtask

    task automatic pulse(input strobe_e st);
        clear_strobes();
        case (st)
            S_ADD:    adder_en = 1;
            S_SUB:    subtractor_en = 1;
            S_BLOAD:  booth_load = 1;
            S_BADD:   booth_add_en = 1;
            S_BSUB:   booth_sub_en = 1;
            S_BSHIFT: booth_shift_en = 1;
            S_BCOUNT: booth_count_en = 1;
            S_DLOAD:  divider_load = 1;
            S_DADD:   divider_add_en = 1;
            S_DSUB:   divider_sub_en = 1;
            S_DSHIFT: divider_shift_en = 1;
            S_DCOUNT: divider_count_en = 1;
            default:  divider_final_add = 1;
        endcase
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n, input logic o, input logic dz);
`ifdef ALU_DP_STATUS_FLAGS_EN
        check({tag, ".zero"}, flag_zero, z);
        check({tag, ".neg"},  flag_neg,  n);
        check({tag, ".ovf"},  flag_ovf,  o);
        check({tag, ".dbz"},  flag_dbz,  dz);
`else
        check({tag, ".flags"}, {flag_zero, flag_neg, flag_ovf, flag_dbz}, 4'b0000);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".lo"},    result_lo, 8'h00);
        check({tag, ".hi"},    result_hi, 8'h00);
        check({tag, ".bits"},  booth_bits, 2'b00);
        check({tag, ".signR"}, divider_sign_R, 1'b0);
        check({tag, ".mdone"}, booth_counter_done, 1'b1);
        check({tag, ".ddone"}, divider_counter_done, 1'b1);
        check({tag, ".flags"}, {flag_zero, flag_neg, flag_ovf, flag_dbz}, 4'b0000);
    endtask

    task automatic run_addsub(input string tag, input logic is_sub, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, sres, ures;
        logic [7:0] lo;
        logic [7:0] hi;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (is_sub) begin
            ures = int'(a) - int'(b);
            sres = sa - sb;
            hi   = (int'(a) < int'(b)) ? 8'h01 : 8'h00;
        end else begin
            ures = int'(a) + int'(b);
            sres = sa + sb;
            hi   = (ures > 255) ? 8'h01 : 8'h00;
        end
        lo = 8'(ures);
        operand_a = a;
        operand_b = b;
        pulse(is_sub ? S_SUB : S_ADD);
        check({tag, ".lo"}, result_lo, lo);
        check({tag, ".hi"}, result_hi, hi);
        check_flags(tag, lo == 8'h00, lo[7], (sres > 127) || (sres < -128), 1'b0);
    endtask

    // Booth control is driven from the multiplier bit pairs the model predicts; abort_at >= 0 resets during that shift
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b, input int abort_at);
        int p;
        logic [15:0] prod;
        logic prev;
        logic [1:0] bits;
        p = int'($signed(a)) * int'($signed(b));
        prod = 16'(p);
        operand_a = a;
        operand_b = b;
        pulse(S_BLOAD);
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits = {a[i], prev};
            check($sformatf("%s.bits%0d", tag, i), booth_bits, bits);
            if (bits == 2'b01) pulse(S_BADD);
            if (bits == 2'b10) pulse(S_BSUB);
            if (i == abort_at) begin
                booth_shift_en = 1;
                #2;
                reset = 1;
                #1;
                check_reset_state({tag, ".rst"});
                @(posedge clk);
                #1;
                booth_shift_en = 0;
                reset = 0;
                return;
            end
            pulse(S_BSHIFT);
            check($sformatf("%s.mdone%0d", tag, i), booth_counter_done, (i == 7));
            pulse(S_BCOUNT);
            prev = a[i];
        end
        check({tag, ".mdone_end"}, booth_counter_done, 1'b1);
        check({tag, ".prod"}, {result_hi, result_lo}, prod);
        check_flags(tag, prod == 16'h0000, prod[15], 1'b0, 1'b0);
    endtask

    // Remainder sign after each step is negative exactly when that quotient bit is 0
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        logic [7:0] rem;
        logic neg;
        q   = (b == 8'h00) ? 8'hFF : 8'(int'(a) / int'(b));
        rem = (b == 8'h00) ? a     : 8'(int'(a) % int'(b));
        operand_a = a;
        operand_b = b;
        pulse(S_DLOAD);
        check({tag, ".ddone_load"}, divider_counter_done, 1'b0);
        neg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse(S_DSHIFT);
            pulse(neg ? S_DADD : S_DSUB);
            neg = ~q[7-i];
            check($sformatf("%s.signR%0d", tag, i), divider_sign_R, neg);
            check($sformatf("%s.ddone%0d", tag, i), divider_counter_done, (i == 7));
            pulse(S_DCOUNT);
        end
        pulse(S_DFINAL);
        check({tag, ".quot"}, result_lo, q);
        check({tag, ".rem"},  result_hi, rem);
        check({tag, ".signR_end"}, divider_sign_R, 1'b0);
        check_flags(tag, q == 8'h00, q[7], 1'b0, b == 8'h00);
    endtask

    initial begin
        reset = 1;
        operand_a = 0;
        operand_b = 0;
        clear_strobes();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 0;

        run_addsub("add_7f_01", 1'b0, 8'h7F, 8'h01);
        run_addsub("sub_05_07", 1'b1, 8'h05, 8'h07);
        run_addsub("add_ff_01", 1'b0, 8'hFF, 8'h01);
        run_addsub("sub_80_01", 1'b1, 8'h80, 8'h01);
        for (int k = 0; k < 6; k++) begin
            run_addsub($sformatf("rnd_as%0d", k), 1'(k % 2), 8'($urandom), 8'($urandom));
        end

        run_mul("mul_fd_05", 8'hFD, 8'h05, -1);
        run_mul("mul_80_80", 8'h80, 8'h80, -1);
        for (int k = 0; k < 3; k++) begin
            run_mul($sformatf("rnd_mul%0d", k), 8'($urandom), 8'($urandom), -1);
        end

        run_div("div_200_7", 8'd200, 8'd7);
        run_div("div_55_0", 8'h55, 8'h00);
        run_addsub("dbz_clear", 1'b0, 8'h01, 8'h02);
        for (int k = 0; k < 3; k++) begin
            run_div($sformatf("rnd_div%0d", k), 8'($urandom), 8'($urandom_range(255, 1)));
        end

        run_mul("mul_abort", 8'h5A, 8'hC3, 3);
        run_mul("mul_3_4", 8'h03, 8'h04, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Execution datapath for the 8-bit ALU, and the responder to the ALU control unit. It performs add and subtract, radix-2 Booth signed multiply, and non-restoring unsigned divide. Each step runs in response to a one-cycle control strobe, and the block returns the status bits the controller branches on (`booth_bits`, counter-done flags, divider remainder sign). Results are read out when the controller raises `alu_done`.

## Interface
- `WIDTH`, default 8: operand width. The controller protocol fixes it at 8; other values are unsupported.

Ports:
- `clk` in 1: single clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-high. It clears all registers immediately.
- `operand_a` in 8: dividend / multiplier / minuend / addend. Sampled only on a load strobe.
- `operand_b` in 8: divisor / multiplicand / subtrahend / addend. Sampled only on a load strobe.
- `adder_en`, `subtractor_en` in 1: single-cycle add or subtract, with operands sampled on that same edge.
- `booth_load`, `booth_add_en`, `booth_sub_en`, `booth_shift_en`, `booth_count_en` in 1: multiplier step strobes.
- `divider_load`, `divider_add_en`, `divider_sub_en`, `divider_shift_en`, `divider_count_en`, `divider_final_add` in 1: divider step strobes.
- `booth_bits` out 2: `{Q[0], Q_1}` of the multiplier.
- `booth_counter_done` out 1: `mcount == 0`.
- `divider_sign_R` out 1: `R[9]`.
- `divider_counter_done` out 1: `dcount == 0`.
- `result_lo`, `result_hi` out 8: result of the last operation class.
- `flag_zero`, `flag_neg`, `flag_ovf`, `flag_dbz` out 1: status flags (see Configuration).

## Operation
Operation class:
- A 2-bit `op_sel` register records the class: 00 add, 01 sub, 10 mul, 11 div.
- `op_sel` is written by `adder_en`, `subtractor_en`, `booth_load` or `divider_load`.
- The result mux selects on `op_sel`.

Add / subtract:
- `adder_en`: `{c, s} <= a + b`, 9 bits.
- `subtractor_en`: `s <= a - b`, `c <= (a < b)` unsigned borrow.
- Result: `result_lo = s`, `result_hi = {7'b0, c}`.

Multiply:
- Registers: `Acc` 9-bit signed, `Q` 8, `Q_1` 1, `M` 9 (sign-extended b), `mcount` 3.
- `booth_load`: `Acc <= 0`, `Q <= a`, `Q_1 <= 0`, `M <= sext(b)`, `mcount <= 7`.
- `booth_add_en`: `Acc <= Acc + M`. `booth_sub_en`: `Acc <= Acc - M`. Both are 9-bit and wrap.
- `booth_shift_en`: `{Acc, Q, Q_1} <= arithmetic right shift by 1`.
- `booth_count_en`: `mcount <= mcount - 1`; it saturates at 0.
- Result: `{result_hi, result_lo} = {Acc[7:0], Q}`, a signed 16-bit product.

Divide (unsigned):
- Registers: `R` 10-bit signed, `Q` 8, `D` 8, `dcount` 3.
- `divider_load`: `R <= 0`, `Q <= a`, `D <= b`, `dcount <= 7`.
- `divider_shift_en`: `{R, Q} <= {R, Q} << 1`, with `Q[0] <= 0`.
- `divider_add_en`: `R <= R + D`. `divider_sub_en`: `R <= R - D`. In both cases `Q[0] <= ~sign(new R)`.
- `divider_count_en`: `dcount` decrements, saturating at 0.
- `divider_final_add`: `R <= R + D` only if `R[9] = 1`; otherwise R holds.
- Result: `result_lo = Q` (quotient), `result_hi = R[7:0]` (remainder).
- Divide by zero produces Q = 0xFF and R = a. There is no trap.

Strobe handling:
- The multiplier and divider register sets are independent, so strobes to different units all take effect on the same edge.
- Within one unit the priority is load > add > sub > shift > count/final_add.
- Add/sub strobes override any mul/div strobe for `op_sel`.
- With no strobe asserted, every register holds.

## Timing
Latency:
- Every strobe takes effect on the edge that samples it.
- All outputs are combinational from registers only. There is no strobe-to-output path.
- Add and sub results are valid 1 cycle after the strobe.
- Status outputs are valid in the cycle after the edge that updated them. `booth_bits` after `booth_load` is `{a[0], 0}`.
- `*_counter_done` is high during the 8th count strobe, so exactly 8 iterations run.

Reset state (registers at 0), applied at assertion, including mid-operation:
- `result_lo`, `result_hi`, `booth_bits` = 0.
- `divider_sign_R` = 0.
- `booth_counter_done` = 1 and `divider_counter_done` = 1.
- All flags = 0.
- A partial multiply or divide is discarded. The next load restarts it cleanly.

## Configuration
Macro `ALU_DP_STATUS_FLAGS_EN`.

When defined, the flags are computed combinationally from the selected result:
- `flag_zero` = selected 8-bit (add/sub/div) or 16-bit (mul) result equals 0.
- `flag_neg` = MSB of that result.
- `flag_ovf` = signed overflow of add/sub, else 0.
- `flag_dbz` is registered: set by `divider_load` when b = 0, and cleared by any other load strobe.

When undefined, the flag ports remain present, are tied to 0, and no flag logic is built.

## Test plan
- `adder_en` with a=0x7F, b=0x01: `result_lo`=0x80, `result_hi`=0x00; with macro, `flag_ovf`=1 and `flag_neg`=1.
- `subtractor_en` with a=0x05, b=0x07: `result_lo`=0xFE, `result_hi`=0x01.
- Booth sequence driven per `booth_bits` with a=0xFD (−3), b=0x05: after the 8th count, `booth_counter_done`=1 and `{hi,lo}`=0xFFF1. With a=b=0x80: 0x4000.
- Non-restoring sequence with a=200, b=7: `divider_sign_R` toggles as expected, and after `divider_final_add`, `result_lo`=0x1C and `result_hi`=0x04.
- Divide with a=0x55, b=0x00: `result_lo`=0xFF, `result_hi`=0x55; with macro, `flag_dbz`=1.
- Assert `reset` asynchronously during the 4th multiply shift: all outputs read reset values immediately. A fresh `booth_load` with a=3, b=4 then yields 0x000C.
